// File: rtl/coarse_peak_finder.sv
// Coarse peak finder: bins TDC timestamps into a 2^NB-bin histogram over a
// frame of laser cycles, then scans the bins and reports the tallest one.
module coarse_peak_finder #(
  parameter int NB          = 4,
  parameter int NP          = 12,
  parameter int CW          = 8,
  parameter int FRAME_LASER = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          laser_sync,
  input  logic          tdc_valid,
  input  logic [NP-1:0] tdc_data,
  output logic [NB-1:0] peakCH,
  output logic [CW-1:0] peakCount,
  output logic          peakEmpty,
  output logic          peakReady,
  output logic          busy
);

  localparam int NBINS = 1 << NB;
  localparam int LCW   = $clog2(FRAME_LASER + 1);
  localparam logic [CW-1:0]  CNT_MAX    = {CW{1'b1}};
  localparam logic [LCW-1:0] LASER_LAST = LCW'(FRAME_LASER - 1);
  localparam logic [NB-1:0]  IDX_LAST   = NB'(NBINS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   bin_q [NBINS];
  logic [CW-1:0]   bin_d [NBINS];
  logic [LCW-1:0]  laser_cnt_q, laser_cnt_d;
  logic [NB-1:0]   scan_idx_q, scan_idx_d;
  logic [CW-1:0]   max_val_q, max_val_d;
  logic [NB-1:0]   max_idx_q, max_idx_d;
  logic [NB-1:0]   peak_ch_q, peak_ch_d;
  logic [CW-1:0]   peak_count_q, peak_count_d;
  logic            peak_empty_q, peak_empty_d;
  logic            peak_ready_q, peak_ready_d;

  logic [NB-1:0]   tdc_bin;
  logic [CW-1:0]   scan_val;
  logic [CW-1:0]   cand_val;
  logic [NB-1:0]   cand_idx;

  assign tdc_bin  = tdc_data[NP-1:NP-NB];
  assign scan_val = bin_q[scan_idx_q];

  // Bin 0 seeds the running max; later bins replace it only when strictly
  // larger, so ties (including saturated bins) keep the lowest index.
  always_comb begin
    cand_val = max_val_q;
    cand_idx = max_idx_q;
    if ((scan_idx_q == '0) || (scan_val > max_val_q)) begin
      cand_val = scan_val;
      cand_idx = scan_idx_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    laser_cnt_d  = laser_cnt_q;
    scan_idx_d   = scan_idx_q;
    max_val_d    = max_val_q;
    max_idx_d    = max_idx_q;
    peak_ch_d    = peak_ch_q;
    peak_count_d = peak_count_q;
    peak_empty_d = peak_empty_q;
    peak_ready_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A start coinciding with the result strobe belongs to the frame
        // that is just finishing, so it is dropped.
        if (start && !peak_ready_q) begin
          for (int i = 0; i < NBINS; i++) begin
            bin_d[i] = '0;
          end
          laser_cnt_d = '0;
          scan_idx_d  = '0;
          state_d     = S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (tdc_valid && (bin_q[tdc_bin] != CNT_MAX)) begin
          bin_d[tdc_bin] = bin_q[tdc_bin] + CW'(1);
        end
        if (laser_sync) begin
          laser_cnt_d = laser_cnt_q + LCW'(1);
          if (laser_cnt_q == LASER_LAST) begin
            scan_idx_d = '0;
            state_d    = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        max_val_d  = cand_val;
        max_idx_d  = cand_idx;
        scan_idx_d = scan_idx_q + 1'b1;
        if (scan_idx_q == IDX_LAST) begin
          peak_ch_d    = cand_idx;
          peak_count_d = cand_val;
          peak_empty_d = (cand_val == '0);
          peak_ready_d = 1'b1;
          state_d      = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      laser_cnt_q  <= '0;
      scan_idx_q   <= '0;
      max_val_q    <= '0;
      max_idx_q    <= '0;
      peak_ch_q    <= '0;
      peak_count_q <= '0;
      peak_empty_q <= 1'b1;
      peak_ready_q <= 1'b0;
      for (int i = 0; i < NBINS; i++) begin
        bin_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      laser_cnt_q  <= laser_cnt_d;
      scan_idx_q   <= scan_idx_d;
      max_val_q    <= max_val_d;
      max_idx_q    <= max_idx_d;
      peak_ch_q    <= peak_ch_d;
      peak_count_q <= peak_count_d;
      peak_empty_q <= peak_empty_d;
      peak_ready_q <= peak_ready_d;
      for (int i = 0; i < NBINS; i++) begin
        bin_q[i] <= bin_d[i];
      end
    end
  end

  assign peakCH    = peak_ch_q;
  assign peakCount = peak_count_q;
  assign peakEmpty = peak_empty_q;
  assign peakReady = peak_ready_q;
  assign busy      = (state_q == S_ACCUM) || (state_q == S_SCAN);

endmodule

// File: tb/tb_coarse_peak_finder.sv
// Self-checking bench for coarse_peak_finder: a histogram model predicts each
// frame's result into a queue that is checked when peakReady fires.
module tb_coarse_peak_finder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        laser_sync;
  logic        tdc_valid;
  logic [11:0] tdc_data;
  logic [3:0]  peakCH;
  logic [7:0]  peakCount;
  logic        peakEmpty;
  logic        peakReady;
  logic        busy;

  coarse_peak_finder #(.NB(4), .NP(12), .CW(8), .FRAME_LASER(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .laser_sync(laser_sync),
    .tdc_valid(tdc_valid), .tdc_data(tdc_data), .peakCH(peakCH),
    .peakCount(peakCount), .peakEmpty(peakEmpty), .peakReady(peakReady),
    .busy(busy)
  );

  typedef struct {
    logic [3:0] ch;
    logic [7:0] cnt;
    logic       empty;
    int         rcyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] hit_q[$];
  int          hist[16];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Result checker: every peakReady must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n && peakReady) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ready: peakReady at cycle %0d, none expected", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (peakCH !== e.ch || peakCount !== e.cnt || peakEmpty !== e.empty || cyc !== e.rcyc) begin
          n_err++;
          $display("FAIL result: got ch=%0d cnt=%0d empty=%0b cyc=%0d, expected ch=%0d cnt=%0d empty=%0b cyc=%0d",
                   peakCH, peakCount, peakEmpty, cyc, e.ch, e.cnt, e.empty, e.rcyc);
        end else begin
          $display("frame result ch=%0d cnt=%0d empty=%0b at cycle %0d", peakCH, peakCount, peakEmpty, cyc);
        end
      end
    end
  end

  task automatic step(input logic v, input logic [11:0] d, input logic ls, input logic st);
    tdc_valid  = v;
    tdc_data   = d;
    laser_sync = ls;
    start      = st;
    @(posedge clk);
    #1;
    tdc_valid  = 1'b0;
    laser_sync = 1'b0;
    start      = 1'b0;
  endtask

  task automatic model_hit(input logic [11:0] d);
    if (hist[d[11:8]] < 255) hist[d[11:8]]++;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL ready_timeout: %0d results pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_after_done: got %0b, expected 0", busy);
    end
  endtask

  // Starts a frame (with a hit in the start cycle that must be ignored),
  // plays hit_q, then the laser pulses; optionally a hit on the final pulse.
  task automatic run_frame(input bit extra_start, input bit last_hit,
                           input logic [11:0] last_data, input bit push_exp);
    int   last_cyc;
    int   best;
    exp_t e;
    for (int i = 0; i < 16; i++) hist[i] = 0;
    step(1'b1, 12'h7A0, 1'b0, 1'b1);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_after_start: got %0b, expected 1", busy);
    end
    foreach (hit_q[i]) begin
      step(1'b1, hit_q[i], 1'b0, 1'b0);
      model_hit(hit_q[i]);
    end
    for (int p = 0; p < 3; p++) begin
      step(1'b0, 12'h000, 1'b1, 1'b0);
      if (extra_start && p == 0) begin
        step(1'b1, 12'h100, 1'b0, 1'b1);
        model_hit(12'h100);
      end
    end
    last_cyc = cyc;
    step(last_hit, last_data, 1'b1, 1'b0);
    if (last_hit) model_hit(last_data);
    best = 0;
    for (int i = 1; i < 16; i++) if (hist[i] > hist[best]) best = i;
    e.ch    = 4'(best);
    e.cnt   = 8'(hist[best]);
    e.empty = (hist[best] == 0);
    e.rcyc  = last_cyc + 17;
    if (push_exp) exp_q.push_back(e);
    $display("frame driven: %0d hits, expect ch=%0d cnt=%0d empty=%0b", hit_q.size(), e.ch, e.cnt, e.empty);
    if (extra_start) begin
      step(1'b0, 12'h000, 1'b0, 1'b0);
      step(1'b1, 12'h000, 1'b1, 1'b1);
      step(1'b0, 12'h000, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if (peakCH !== 4'd0 || peakCount !== 8'd0 || peakEmpty !== 1'b1 || peakReady !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got ch=%0d cnt=%0d empty=%0b rdy=%0b busy=%0b, expected 0 0 1 0 0",
               peakCH, peakCount, peakEmpty, peakReady, busy);
    end else $display("reset state ok");
  endtask

  task automatic test_frame_peak();
    hit_q.delete();
    for (int i = 0; i < 5; i++) hit_q.push_back(12'h7A0);
    hit_q.push_back(12'h300);
    hit_q.push_back(12'h300);
    run_frame(1'b0, 1'b0, 12'h000, 1'b1);
    wait_done();
  endtask

  task automatic test_tie();
    hit_q.delete();
    for (int i = 0; i < 3; i++) hit_q.push_back(12'h9C4);
    for (int i = 0; i < 3; i++) hit_q.push_back(12'h2F0);
    run_frame(1'b0, 1'b0, 12'h000, 1'b1);
    wait_done();
  endtask

  task automatic test_saturation();
    hit_q.delete();
    for (int i = 0; i < 300; i++) hit_q.push_back(12'hFFF);
    for (int i = 0; i < 10; i++) hit_q.push_back(12'h000);
    run_frame(1'b0, 1'b0, 12'h000, 1'b1);
    wait_done();
  endtask

  task automatic test_last_cycle_hit();
    hit_q.delete();
    for (int i = 0; i < 4; i++) hit_q.push_back(12'h4AA);
    for (int i = 0; i < 4; i++) hit_q.push_back(12'h512);
    run_frame(1'b0, 1'b1, 12'h5EE, 1'b1);
    wait_done();
  endtask

  task automatic test_empty();
    hit_q.delete();
    run_frame(1'b0, 1'b0, 12'h000, 1'b1);
    wait_done();
  endtask

  task automatic test_control();
    hit_q.delete();
    hit_q.push_back(12'h100);
    for (int i = 0; i < 2; i++) hit_q.push_back(12'hB00);
    run_frame(1'b1, 1'b0, 12'h000, 1'b1);
    wait_done();
  endtask

  task automatic test_reset_mid_scan();
    hit_q.delete();
    for (int i = 0; i < 6; i++) hit_q.push_back(12'hD10);
    run_frame(1'b0, 1'b0, 12'h000, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 12'h000, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (peakCH !== 4'd0 || peakCount !== 8'd0 || peakEmpty !== 1'b1 || peakReady !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_scan: got ch=%0d cnt=%0d empty=%0b rdy=%0b busy=%0b, expected 0 0 1 0 0",
               peakCH, peakCount, peakEmpty, peakReady, busy);
    end else $display("reset mid-scan ok");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    hit_q.delete();
    for (int i = 0; i < 2; i++) hit_q.push_back(12'h6AB);
    run_frame(1'b0, 1'b0, 12'h000, 1'b1);
    wait_done();
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    laser_sync = 1'b0;
    tdc_valid  = 1'b0;
    tdc_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_frame_peak();
    test_tie();
    test_saturation();
    test_last_cycle_hit();
    test_empty();
    test_control();
    test_reset_mid_scan();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
